// File: rtl/sram_bist_engine.sv
// March BIST for a 1rw1r SRAM: write P, read/compare, write ~P, read/compare.
// Mismatch results are held for the register file until the next start, abort or reset.
module sram_bist_engine #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_phase,
    output logic              csb0,
    output logic              web0,
    output logic [ADDR_W-1:0] addr0,
    output logic [DATA_W-1:0] din0,
    output logic              csb1,
    output logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] dout1
);

    // state  | meaning
    // IDLE   | waiting for start, SRAM ports deselected
    // WRITE0 | write P(a) to every address on port 0
    // READ0  | read every address on port 1, expect P(a)
    // DRAIN0 | READ_LAT cycles letting the last reads reach the comparator
    // WRITE1 | write ~P(a)
    // READ1  | read back, expect ~P(a)
    // DRAIN1 | final drain
    // DONE   | results valid, held until start/abort/rst
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE0, S_READ0, S_DRAIN0, S_WRITE1, S_READ1, S_DRAIN1, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};
    localparam logic [1:0]        DRAIN_LOAD = 2'(READ_LAT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        drain_q, drain_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              fe_valid_q, fe_valid_d;
    logic [ADDR_W-1:0] fe_addr_q, fe_addr_d;
    logic              fe_phase_q, fe_phase_d;

    // Read-compare delay line: stage READ_LAT-1 lines up with dout1.
    logic              pl_vld_q   [READ_LAT];
    logic              pl_vld_d   [READ_LAT];
    logic [ADDR_W-1:0] pl_addr_q  [READ_LAT];
    logic [ADDR_W-1:0] pl_addr_d  [READ_LAT];
    logic [DATA_W-1:0] pl_exp_q   [READ_LAT];
    logic [DATA_W-1:0] pl_exp_d   [READ_LAT];
    logic              pl_phase_q [READ_LAT];
    logic              pl_phase_d [READ_LAT];

    logic              in_write, in_read, in_drain, in_busy, phase;
    logic              start_go, abort_go, addr_tc, drain_tc, mismatch;
    logic [DATA_W-1:0] pattern, word;

    assign in_write = (state_q == S_WRITE0) || (state_q == S_WRITE1);
    assign in_read  = (state_q == S_READ0)  || (state_q == S_READ1);
    assign in_drain = (state_q == S_DRAIN0) || (state_q == S_DRAIN1);
    assign in_busy  = in_write || in_read || in_drain;
    assign phase    = (state_q == S_WRITE1) || (state_q == S_READ1);
    assign start_go = start && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign abort_go = abort && in_busy;
    assign addr_tc  = (addr_q == LAST_ADDR);
    assign drain_tc = (drain_q == 2'd0);
    assign pattern  = mode_q ? (addr_q[0] ? ~seed_q : seed_q) : seed_q + DATA_W'(addr_q);
    assign word     = phase ? ~pattern : pattern;
    assign mismatch = pl_vld_q[READ_LAT-1] && (dout1 != pl_exp_q[READ_LAT-1]);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort_go) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start_go) state_d = S_WRITE0;
                S_WRITE0:       if (addr_tc)  state_d = S_READ0;
                S_READ0:        if (addr_tc)  state_d = S_DRAIN0;
                S_DRAIN0:       if (drain_tc) state_d = S_WRITE1;
                S_WRITE1:       if (addr_tc)  state_d = S_READ1;
                S_READ1:        if (addr_tc)  state_d = S_DRAIN1;
                S_DRAIN1:       if (drain_tc) state_d = S_DONE;
                default:                      state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy  = in_busy;
        done  = (state_q == S_DONE);
        pass  = (state_q == S_DONE) && (err_cnt_q == 8'd0);
        csb0  = !in_write;
        web0  = !in_write;
        addr0 = in_write ? addr_q : '0;
        din0  = in_write ? word : '0;
        csb1  = !in_read;
        addr1 = in_read ? addr_q : '0;
    end

    assign err_count       = err_cnt_q;
    assign first_err_valid = fe_valid_q;
    assign first_err_addr  = fe_addr_q;
    assign first_err_phase = fe_phase_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            drain_q    <= '0;
            mode_q     <= 1'b0;
            seed_q     <= '0;
            err_cnt_q  <= '0;
            fe_valid_q <= 1'b0;
            fe_addr_q  <= '0;
            fe_phase_q <= 1'b0;
            for (int i = 0; i < READ_LAT; i++) begin
                pl_vld_q[i]   <= 1'b0;
                pl_addr_q[i]  <= '0;
                pl_exp_q[i]   <= '0;
                pl_phase_q[i] <= 1'b0;
            end
        end else begin
            addr_q     <= addr_d;
            drain_q    <= drain_d;
            mode_q     <= mode_d;
            seed_q     <= seed_d;
            err_cnt_q  <= err_cnt_d;
            fe_valid_q <= fe_valid_d;
            fe_addr_q  <= fe_addr_d;
            fe_phase_q <= fe_phase_d;
            for (int i = 0; i < READ_LAT; i++) begin
                pl_vld_q[i]   <= pl_vld_d[i];
                pl_addr_q[i]  <= pl_addr_d[i];
                pl_exp_q[i]   <= pl_exp_d[i];
                pl_phase_q[i] <= pl_phase_d[i];
            end
        end
    end

    always_comb begin
        addr_d     = addr_q;
        drain_d    = drain_q;
        mode_d     = mode_q;
        seed_d     = seed_q;
        err_cnt_d  = err_cnt_q;
        fe_valid_d = fe_valid_q;
        fe_addr_d  = fe_addr_q;
        fe_phase_d = fe_phase_q;
        pl_vld_d[0]   = in_read;
        pl_addr_d[0]  = addr_q;
        pl_exp_d[0]   = word;
        pl_phase_d[0] = phase;
        for (int i = 1; i < READ_LAT; i++) begin
            pl_vld_d[i]   = pl_vld_q[i-1];
            pl_addr_d[i]  = pl_addr_q[i-1];
            pl_exp_d[i]   = pl_exp_q[i-1];
            pl_phase_d[i] = pl_phase_q[i-1];
        end
        // Address counter wraps to 0 on the last address, ready for the next sweep.
        if (in_write || in_read) addr_d = addr_q + 1'b1;
        if (in_read)                    drain_d = DRAIN_LOAD;
        else if (in_drain && !drain_tc) drain_d = drain_q - 1'b1;
        if (mismatch) begin
            if (err_cnt_q != 8'hff) err_cnt_d = err_cnt_q + 8'd1;
            if (!fe_valid_q) begin
                fe_valid_d = 1'b1;
                fe_addr_d  = pl_addr_q[READ_LAT-1];
                fe_phase_d = pl_phase_q[READ_LAT-1];
            end
        end
        if (start_go || abort_go) begin
            addr_d     = '0;
            err_cnt_d  = '0;
            fe_valid_d = 1'b0;
            fe_addr_d  = '0;
            fe_phase_d = 1'b0;
            for (int i = 0; i < READ_LAT; i++) pl_vld_d[i] = 1'b0;
            if (start_go) begin
                mode_d = mode;
                seed_d = seed;
            end
        end
    end

endmodule

// File: tb/tb_sram_bist_engine.sv
// Bench for sram_bist_engine: two instances (16x32 lat 1, 256x32 lat 2) each driving
// a behavioural SRAM with injectable read faults, checked against a march reference model.
module tb_sram_bist_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, abort, mode, a_start, b_start;
    logic [31:0] seed;
    logic [31:0] f_and = '1;
    logic [31:0] f_xor = '0;
    int n_cmp = 0;
    int n_bad = 0;

    logic        a_busy, a_done, a_pass, a_fev, a_feph, a_csb0, a_web0, a_csb1;
    logic [7:0]  a_err;
    logic [3:0]  a_fea, a_addr0, a_addr1;
    logic [31:0] a_din0, a_dout1;

    logic        b_busy, b_done, b_pass, b_fev, b_feph, b_csb0, b_web0, b_csb1;
    logic [7:0]  b_err;
    logic [7:0]  b_fea, b_addr0, b_addr1;
    logic [31:0] b_din0, b_dout1;

    sram_bist_engine #(.ADDR_W(4), .DATA_W(32), .READ_LAT(1)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(abort), .mode(mode), .seed(seed),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
        .first_err_valid(a_fev), .first_err_addr(a_fea), .first_err_phase(a_feph),
        .csb0(a_csb0), .web0(a_web0), .addr0(a_addr0), .din0(a_din0),
        .csb1(a_csb1), .addr1(a_addr1), .dout1(a_dout1));

    sram_bist_engine #(.ADDR_W(8), .DATA_W(32), .READ_LAT(2)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(abort), .mode(mode), .seed(seed),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
        .first_err_valid(b_fev), .first_err_addr(b_fea), .first_err_phase(b_feph),
        .csb0(b_csb0), .web0(b_web0), .addr0(b_addr0), .din0(b_din0),
        .csb1(b_csb1), .addr1(b_addr1), .dout1(b_dout1));

    logic [31:0] mem_a [16];
    logic [31:0] mem_b [256];
    logic [31:0] rd_a = '0;
    logic [31:0] rd_b0 = '0;
    logic [31:0] rd_b1 = '0;

    always @(posedge clk) begin
        if (!a_csb0 && !a_web0) mem_a[a_addr0] <= a_din0;
        if (!a_csb1) rd_a <= mem_a[a_addr1];
        if (!b_csb0 && !b_web0) mem_b[b_addr0] <= b_din0;
        if (!b_csb1) rd_b0 <= mem_b[b_addr1];
        rd_b1 <= rd_b0;
    end
    assign a_dout1 = (rd_a & f_and) ^ f_xor;
    assign b_dout1 = (rd_b1 & f_and) ^ f_xor;

    int          wq_addr [$];
    logic [31:0] wq_data [$];
    int          overlap = 0;
    always @(negedge clk) begin
        if (!a_csb0 && !a_web0) begin wq_addr.push_back(int'(a_addr0)); wq_data.push_back(a_din0); end
        if (!b_csb0 && !b_web0) begin wq_addr.push_back(int'(b_addr0)); wq_data.push_back(b_din0); end
        if ((!a_csb0 && !a_csb1) || (!b_csb0 && !b_csb1)) overlap++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pat(input logic m, input logic [31:0] s, input int a);
        if (m) return ((a % 2) != 0) ? ~s : s;
        return s + 32'(a);
    endfunction

    // Reference march: every address written then read back through the fault masks.
    task automatic model(input logic m, input logic [31:0] s, input int n,
                         output int cnt, output bit fv, output int fa, output bit fph);
        logic [31:0] w, r;
        cnt = 0; fv = 0; fa = 0; fph = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < n; a++) begin
                w = pat(m, s, a) ^ {32{ph == 1}};
                r = (w & f_and) ^ f_xor;
                if (r != w) begin
                    cnt++;
                    if (!fv) begin fv = 1; fa = a; fph = ph[0]; end
                end
            end
        end
    endtask

    task automatic run_test(input int inst, input logic m, input logic [31:0] s, input string name);
        int n, lat, cyc, base, ov, cnt, exp_err, exp_fa, obs_fa, bad_k;
        bit exp_fv, exp_fph, ok;
        logic [31:0] exp_w;
        n = inst ? 256 : 16;
        lat = inst ? 2 : 1;
        model(m, s, n, cnt, exp_fv, exp_fa, exp_fph);
        exp_err = (cnt > 255) ? 255 : cnt;
        base = wq_addr.size();
        ov = overlap;
        @(posedge clk); #1;
        mode = m; seed = s;
        if (inst != 0) b_start = 1'b1; else a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0; b_start = 1'b0;
        mode = ~m; seed = ~s;
        cyc = 1;
        n_cmp++;
        if ((inst ? b_busy : a_busy) !== 1'b1 || (inst ? b_done : a_done) !== 1'b0) begin
            n_bad++;
            $display("FAIL %s start: busy=%b done=%b, required busy=1 done=0", name,
                     inst ? b_busy : a_busy, inst ? b_done : a_done);
        end
        while ((inst ? b_done : a_done) !== 1'b1 && cyc < 4*n + 2*lat + 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if (cyc != 4*n + 2*lat + 1) begin
            n_bad++;
            $display("FAIL %s done_latency: got %0d cycles, required %0d", name, cyc, 4*n + 2*lat + 1);
        end
        n_cmp++;
        if (int'(inst ? b_err : a_err) != exp_err) begin
            n_bad++;
            $display("FAIL %s err_count: got %0d, required %0d", name, inst ? b_err : a_err, exp_err);
        end
        obs_fa = inst ? int'(b_fea) : int'(a_fea);
        n_cmp++;
        if ((inst ? b_fev : a_fev) !== exp_fv || obs_fa != exp_fa || (inst ? b_feph : a_feph) !== exp_fph) begin
            n_bad++;
            $display("FAIL %s first_err: got valid=%b addr=%0d phase=%b, required valid=%b addr=%0d phase=%b",
                     name, inst ? b_fev : a_fev, obs_fa, inst ? b_feph : a_feph, exp_fv, exp_fa, exp_fph);
        end
        n_cmp++;
        if ((inst ? b_pass : a_pass) !== (exp_err == 0)) begin
            n_bad++;
            $display("FAIL %s pass: got %b, required %b", name, inst ? b_pass : a_pass, exp_err == 0);
        end
        ok = (wq_addr.size() - base == 2*n);
        bad_k = -1;
        exp_w = '0;
        for (int k = 0; ok && k < 2*n; k++) begin
            exp_w = pat(m, s, k % n) ^ {32{k >= n}};
            if (wq_addr[base+k] != k % n || wq_data[base+k] !== exp_w) begin ok = 0; bad_k = k; end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            if (bad_k < 0)
                $display("FAIL %s write_stream: got %0d writes, required %0d", name, wq_addr.size() - base, 2*n);
            else
                $display("FAIL %s write_stream[%0d]: got addr=%0d din=%h, required addr=%0d din=%h", name,
                         bad_k, wq_addr[base+bad_k], wq_data[base+bad_k], bad_k % n, exp_w);
        end
        n_cmp++;
        if (overlap != ov) begin
            n_bad++;
            $display("FAIL %s port_overlap: got %0d cycles with both ports selected, required 0", name, overlap - ov);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({a_busy, a_done, a_pass, a_err, a_fev, a_fea, a_feph, a_csb0, a_web0, a_csb1, a_addr0, a_addr1, a_din0}
            !== {3'b000, 8'd0, 1'b0, 4'd0, 1'b0, 3'b111, 4'd0, 4'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL reset_a: got busy=%b done=%b err=%0d fev=%b csb0=%b web0=%b csb1=%b din0=%h, required 0,0,0,0,1,1,1,0",
                     a_busy, a_done, a_err, a_fev, a_csb0, a_web0, a_csb1, a_din0);
        end
        n_cmp++;
        if ({b_busy, b_done, b_pass, b_err, b_fev, b_fea, b_feph, b_csb0, b_web0, b_csb1, b_addr0, b_addr1, b_din0}
            !== {3'b000, 8'd0, 1'b0, 8'd0, 1'b0, 3'b111, 8'd0, 8'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL reset_b: got busy=%b done=%b err=%0d fev=%b csb0=%b web0=%b csb1=%b din0=%h, required 0,0,0,0,1,1,1,0",
                     b_busy, b_done, b_err, b_fev, b_csb0, b_web0, b_csb1, b_din0);
        end
        rst = 1'b0;
    endtask

    task automatic test_incrementing;
        f_and = '1; f_xor = '0;
        run_test(0, 1'b0, 32'h0, "incr_seed0");
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (a_done !== 1'b1 || a_pass !== 1'b1) begin
            n_bad++;
            $display("FAIL done_hold: got done=%b pass=%b, required 1 1", a_done, a_pass);
        end
    endtask

    task automatic test_stuck_bit;
        f_and = ~32'h8; f_xor = '0;
        run_test(0, 1'b0, 32'h0, "stuck_bit3");
        n_cmp++;
        if (a_err !== 8'd16 || a_fea !== 4'd8 || a_feph !== 1'b0) begin
            n_bad++;
            $display("FAIL stuck_bit3_fixed: got err=%0d addr=%0d phase=%b, required 16 8 0", a_err, a_fea, a_feph);
        end
        f_and = '1;
    endtask

    task automatic test_saturation;
        f_and = '1; f_xor = '1;
        run_test(1, 1'b0, $urandom, "saturate");
        f_xor = '0;
    endtask

    task automatic test_checkerboard;
        f_and = '1; f_xor = '0;
        run_test(1, 1'b1, 32'h5555_5555, "checker_lat2");
        run_test(0, 1'b1, 32'h5555_5555, "checker_lat1");
    endtask

    task automatic test_back_to_back;
        run_test(0, 1'b0, 32'hFFFF_FFF8, "b2b_wrap");
        run_test(0, 1'b1, $urandom, "b2b_checker");
    endtask

    task automatic test_abort;
        int cyc;
        f_and = ~32'h8; f_xor = '0;
        @(posedge clk); #1;
        mode = 1'b0; seed = '0; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        cyc = 1;
        repeat (4) begin @(posedge clk); #1; cyc++; end
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        cyc++;
        n_cmp++;
        if (a_csb0 !== 1'b0 || a_addr0 !== 4'd5) begin
            n_bad++;
            $display("FAIL start_ignored: got csb0=%b addr0=%0d, required 0 5", a_csb0, a_addr0);
        end
        while (cyc < 30) begin @(posedge clk); #1; cyc++; end
        n_cmp++;
        if (a_csb1 !== 1'b0 || a_err !== 8'd4 || a_fea !== 4'd8) begin
            n_bad++;
            $display("FAIL mid_read0: got csb1=%b err=%0d addr=%0d, required 0 4 8", a_csb1, a_err, a_fea);
        end
        abort = 1'b1; a_start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; a_start = 1'b0;
        n_cmp++;
        if ({a_busy, a_done, a_csb0, a_csb1, a_err, a_fev} !== {1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL abort: got busy=%b done=%b csb0=%b csb1=%b err=%0d fev=%b, required 0 0 1 1 0 0",
                     a_busy, a_done, a_csb0, a_csb1, a_err, a_fev);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_beats_start: got busy=%b, required 0", a_busy);
        end
        f_and = '1;
        run_test(0, 1'b0, 32'h1234_5678, "after_abort");
    endtask

    task automatic test_reset_mid_run;
        logic [31:0] s;
        s = $urandom;
        f_and = '1; f_xor = '0;
        @(posedge clk); #1;
        mode = 1'b0; seed = s; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        n_cmp++;
        if (a_csb0 !== 1'b0 || a_addr0 !== 4'd6 || a_din0 !== ~(s + 32'd6)) begin
            n_bad++;
            $display("FAIL in_write1: got csb0=%b addr0=%0d din0=%h, required 0 6 %h", a_csb0, a_addr0, a_din0, ~(s + 32'd6));
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({a_busy, a_done, a_pass, a_err, a_fev, a_fea, a_feph, a_csb0, a_web0, a_csb1, a_addr0, a_addr1, a_din0}
            !== {3'b000, 8'd0, 1'b0, 4'd0, 1'b0, 3'b111, 4'd0, 4'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL reset_mid_run: got busy=%b done=%b csb0=%b web0=%b csb1=%b addr0=%0d din0=%h, required 0 0 1 1 1 0 0",
                     a_busy, a_done, a_csb0, a_web0, a_csb1, a_addr0, a_din0);
        end
        rst = 1'b0;
        run_test(0, 1'b0, $urandom, "after_reset");
    endtask

    task automatic test_random;
        logic m;
        for (int i = 0; i < 8; i++) begin
            m = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       begin f_and = '1;                                 f_xor = '0; end
                1:       begin f_and = ~(32'h1 << $urandom_range(0, 31)); f_xor = '0; end
                2:       begin f_and = '1; f_xor = 32'h1 << $urandom_range(0, 31); end
                default: begin f_and = $urandom;                           f_xor = '0; end
            endcase
            run_test(0, m, $urandom, "random");
        end
        f_and = '1; f_xor = '0;
    endtask

    initial begin
        rst = 1'b1; abort = 1'b0; mode = 1'b0; a_start = 1'b0; b_start = 1'b0; seed = '0;
        test_reset();
        test_incrementing();
        test_stuck_bit();
        test_saturation();
        test_checkerboard();
        test_back_to_back();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_bist_engine.md
Name: sram_bist_engine

Overview:
Built-in self-test engine that sits directly upstream of the 1rw1r SRAM macro (sram_32_16_sky130 class) in the user project. It drives port 0 (write) and port 1 (read) with a two-phase march: write pattern, read/compare, write inverse, read/compare. Results are held for the Wishbone register file and LA probes. It replaces the free-running counter pattern generator when a self-test is requested.

Parameters:
ADDR_W, 4, SRAM address width; depth = 2^ADDR_W.
DATA_W, 32, SRAM word width.
READ_LAT, 1, cycles from address on addr1 to valid dout1; legal range 1..3.

Ports:
clk  in  1  clock (same clock as SRAM clk0/clk1).
rst  in  1  synchronous, active-high reset.
start  in  1  single-cycle request; sampled only in IDLE or DONE.
abort  in  1  cancels a running test.
mode  in  1  0 = incrementing (seed + addr), 1 = checkerboard.
seed  in  DATA_W  pattern seed.
busy  out  1  test in progress.
done  out  1  test finished; held until next start, abort or rst.
pass  out  1  done && err_count == 0.
err_count  out  8  saturating mismatch count.
first_err_valid  out  1  at least one mismatch recorded.
first_err_addr  out  ADDR_W  address of first mismatch.
first_err_phase  out  1  phase of first mismatch (0 = true pattern, 1 = inverse).
csb0  out  1  port-0 chip select, active low.
web0  out  1  port-0 write enable, active low.
addr0  out  ADDR_W  port-0 address.
din0  out  DATA_W  port-0 write data.
csb1  out  1  port-1 chip select, active low.
addr1  out  ADDR_W  port-1 address.
dout1  in  DATA_W  port-1 read data.

Behaviour:
- Reset and idle values: busy = done = pass = 0; err_count = 0; first_err_* = 0; csb0 = web0 = csb1 = 1; addr0 = addr1 = 0; din0 = 0.
- States: IDLE, WRITE0, READ0, DRAIN0, WRITE1, READ1, DRAIN1, DONE.
- start in IDLE or DONE: captures mode and seed, clears all results, moves to WRITE0. start in any other state is ignored.
- Pattern: P(a) = seed + zero-extended a, modulo 2^DATA_W (mode 0), or P(a) = a[0] ? ~seed : seed (mode 1). Phase 1 uses ~P(a).
- WRITE0/WRITE1: one address per cycle, a = 0 .. 2^ADDR_W-1. csb0 = 0, web0 = 0, addr0 = a, din0 = P(a) or ~P(a). After the last address, go to READn.
- READ0/READ1: one address per cycle, a = 0 .. 2^ADDR_W-1. csb1 = 0, addr1 = a. Address, expected value and valid bit enter a READ_LAT-deep delay line.
- DRAIN0/DRAIN1: READ_LAT cycles with csb1 = 1 while the delay line empties. DRAIN0 goes to WRITE1; DRAIN1 goes to DONE.
- Compare: for an address issued in cycle c, dout1 is compared at the end of cycle c + READ_LAT.
- On mismatch: err_count increments and saturates at 255. If first_err_valid = 0, it is set and first_err_addr/first_err_phase are captured.
- Results become visible the cycle after the compare.
- busy = 1 in WRITE0 through DRAIN1. done = 1 only in DONE.
- Timing: done rises exactly 4·2^ADDR_W + 2·READ_LAT + 1 cycles after the start edge.
- abort while busy: next cycle is IDLE. Chip selects go high, results are cleared, done = 0. abort in IDLE or DONE has no effect.
- abort and start in the same cycle: abort wins.
- rst overrides everything, at any state.
- Port 0 and port 1 are never both selected in the same cycle.

Test Plan:
1. ADDR_W=4, READ_LAT=1, ideal SRAM model, mode=0, seed=0x0000_0000, start at edge t → busy=1 from t+1; addr0 sweeps 0..15 with din0 = 0..15; done=1 and pass=1 at t+67; err_count=0.
2. SRAM model with dout1[3] stuck at 0, mode=0, seed=0 → err_count=16; first_err_addr=8; first_err_phase=0; pass=0.
3. ADDR_W=8, model returns the inverse of stored data → 512 mismatches; err_count saturates at 255; first_err_addr=0.
4. mode=1, seed=0x5555_5555, READ_LAT=2, ideal model → din0 alternates 0x5555_5555/0xAAAA_AAAA in phase 0 and is inverted in phase 1; done at t+69; pass=1.
5. abort during READ0 with a start pulse mid-WRITE0 → start ignored; cycle after abort: state IDLE, busy=0, csb0=csb1=1, err_count=0; a fresh start completes with pass=1.
6. rst asserted during WRITE1 → next cycle all outputs at reset values; a subsequent start runs a full test to pass=1.
